tx_packet_ctrl: RTL and testbench
=================================

# tx_packet_ctrl

Sequences one USB device-to-host packet onto the byte-serial NRZI encoder. On a start request it issues SYNC, PID, the payload bytes pulled from the TX buffer, and the CRC16 (data packets only), then requests EOP. It sits between the protocol layer/TX FIFO and the encoder, and owns all byte-level handshaking with the encoder.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE
- tx_pid  in  4  PID nibble, captured with tx_start
- tx_length  in  7  payload byte count 0..64, captured with tx_start; ignored for handshake PIDs
- buffer_occupancy  in  7  bytes currently held in TX buffer
- tx_packet_data  in  8  head byte of TX buffer, valid whenever occupancy > 0
- byte_done  in  1  encoder pulse: current byte fully shifted out
- eop_done  in  1  encoder pulse: EOP finished
- get_tx_packet_data  out  1  one-cycle pop strobe to TX buffer
- tx_byte  out  8  byte presented to encoder
- tx_enable  out  1  one-cycle load strobe to encoder
- send_eop  out  1  one-cycle EOP request to encoder
- tx_active  out  1  high from accepted start until DONE/ERROR
- tx_done  out  1  one-cycle pulse, packet completed normally
- tx_error  out  1  one-cycle pulse, request rejected or packet aborted

## Operation
- Accepted PIDs: DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110. Any other PID -> ERROR, nothing sent.
- PID byte = {~tx_pid, tx_pid}. SYNC byte = 0x80.
- States: IDLE, LOAD, WAIT, EOP, WAIT_EOP, DONE, ERROR. A 3-bit field selects the byte kind in LOAD: SYNC, PID, DATA, CRC_LO, CRC_HI.
- IDLE: tx_start with valid PID -> LOAD(SYNC); invalid -> ERROR.
- LOAD: drive tx_byte, pulse tx_enable, -> WAIT. For DATA, the same cycle pulses get_tx_packet_data and latches tx_packet_data into tx_byte.
- WAIT: hold tx_byte; on byte_done advance: SYNC->PID; PID->EOP for handshake PIDs, ->DATA if length>0, else ->CRC_LO; DATA->DATA until length bytes sent, then ->CRC_LO; CRC_LO->CRC_HI; CRC_HI->EOP.
- DATA underrun: entering LOAD(DATA) with buffer_occupancy==0 -> EOP immediately (truncated packet), and tx_error pulses in place of tx_done at the end.
- EOP: pulse send_eop -> WAIT_EOP; eop_done -> DONE (or ERROR if underrun flagged). DONE/ERROR: pulse the output, -> IDLE.
- CRC16: reflected poly 0xA001, reset to 0xFFFF on start, updated LSB-first over each DATA byte at its LOAD; transmitted value is ~crc, low byte first.
- Byte counter: 7 bits, cleared on start; equality compare with captured length.
- tx_start outside IDLE is ignored.

## Timing
- Reset: state IDLE, tx_byte 0x00, all strobes and tx_active 0, crc 0xFFFF, counter 0.
- tx_start at edge N -> tx_enable with tx_byte=0x80 at N+1.
- byte_done at edge K -> next tx_enable at K+1 (one-cycle gap); tx_byte changes only in LOAD.
- byte_done and eop_done are ignored outside WAIT/WAIT_EOP.
- tx_active rises the cycle after an accepted start, falls in the DONE/ERROR cycle.
- Asynchronous reset mid-packet: immediate return to reset values; no EOP is issued.

## Configuration
- TX_CTRL_TIMEOUT_EN defined: 8-bit watchdog cleared on each tx_enable/send_eop and counting in WAIT/WAIT_EOP; reaching 255 without byte_done/eop_done -> ERROR (tx_error pulse) -> IDLE.
- Undefined: no watchdog; WAIT states hold indefinitely.

## Test plan
- Reset with strobes idle -> all outputs 0, tx_byte 0x00, tx_active 0.
- tx_start, pid 0010, byte_done after each load -> tx_byte 0x80, 0xD2, then send_eop, eop_done -> tx_done pulse, no pops.
- pid 0011, length 0 -> bytes 0x80, 0xC3, 0x00, 0x00, EOP, tx_done.
- pid 1011, length 1, buffer {0x00} -> bytes 0x80, 0x4B, 0x00, 0x40, 0xBF; exactly one pop; tx_done.
- pid 0011, length 3, occupancy drops to 0 after 1 byte -> one data byte, then send_eop, tx_error after eop_done, no CRC bytes.
- pid 0101 -> tx_error next-but-one cycle, no tx_enable; with TX_CTRL_TIMEOUT_EN, withhold byte_done after SYNC -> tx_error 256 cycles later, back to IDLE.

Source files
------------

// File: rtl/tx_packet_ctrl.sv
// tx_packet_ctrl
//   Sequences one USB device-to-host packet onto the byte-serial NRZI
//   encoder: SYNC, PID, payload bytes popped from the TX buffer, CRC16
//   (data PIDs only), then an EOP request.
//
// Ports
//   clk, n_rst          clock (rising edge) / asynchronous active-low reset
//   tx_start            one-cycle packet request, sampled only in IDLE
//   tx_pid, tx_length   PID nibble and payload byte count, captured on start
//   buffer_occupancy    bytes held in the TX buffer
//   tx_packet_data      head byte of the TX buffer
//   byte_done, eop_done encoder completion pulses
//   get_tx_packet_data  pop strobe to the TX buffer
//   tx_byte, tx_enable  byte and load strobe to the encoder
//   send_eop            EOP request to the encoder
//   tx_active           busy flag, accepted start until DONE/ERROR
//   tx_done, tx_error   completion / rejection-or-abort pulses
//
// Configuration
//   TX_CTRL_TIMEOUT_EN  when defined, an 8-bit watchdog aborts a packet whose
//                       encoder handshake stalls in WAIT/WAIT_EOP.
module tx_packet_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_length,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  input  logic       byte_done,
  input  logic       eop_done,
  output logic       get_tx_packet_data,
  output logic [7:0] tx_byte,
  output logic       tx_enable,
  output logic       send_eop,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_EOP,
    S_WAIT_EOP,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    K_SYNC,
    K_PID,
    K_DATA,
    K_CRC_LO,
    K_CRC_HI
  } kind_t;

  state_t      state;
  kind_t       kind;
  logic [3:0]  pid_q;
  logic [6:0]  len_q;
  logic [6:0]  count;
  logic [15:0] crc;
  logic        underrun;
  logic        wd_expired;

  function automatic logic pid_valid(input logic [3:0] p);
    logic v;
    v = 1'b0;
    case (p)
      4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b1110: v = 1'b1;
      default:                                      v = 1'b0;
    endcase
    return v;
  endfunction

  // DATA0/DATA1 are the only accepted PIDs ending in 2'b11.
  function automatic logic pid_is_data(input logic [3:0] p);
    return (p[1:0] == 2'b11);
  endfunction

  // Reflected CRC16 (0xA001), data bits consumed LSB first.
  function automatic logic [15:0] crc_update(input logic [15:0] c_in,
                                             input logic [7:0]  d);
    logic [15:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

`ifdef TX_CTRL_TIMEOUT_EN
  logic [7:0] wd;

  // Counts only while waiting on the encoder; any other state (including
  // LOAD/EOP, where the strobes are issued) restarts it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd <= '0;
    end else if (state == S_WAIT || state == S_WAIT_EOP) begin
      wd <= wd + 8'd1;
    end else begin
      wd <= '0;
    end
  end

  assign wd_expired = (wd == 8'hFF);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= S_IDLE;
      kind               <= K_SYNC;
      pid_q              <= '0;
      len_q              <= '0;
      count              <= '0;
      crc                <= '1;
      underrun           <= 1'b0;
      tx_byte            <= '0;
      tx_enable          <= 1'b0;
      get_tx_packet_data <= 1'b0;
      send_eop           <= 1'b0;
      tx_active          <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      tx_enable          <= 1'b0;
      get_tx_packet_data <= 1'b0;
      send_eop           <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tx_start) begin
            if (pid_valid(tx_pid)) begin
              pid_q     <= tx_pid;
              len_q     <= tx_length;
              count     <= '0;
              crc       <= '1;
              underrun  <= 1'b0;
              kind      <= K_SYNC;
              tx_active <= 1'b1;
              state     <= S_LOAD;
            end else begin
              state <= S_ERROR;
            end
          end
        end

        S_LOAD: begin
          state <= S_WAIT;
          case (kind)
            K_SYNC: begin
              tx_byte   <= 8'h80;
              tx_enable <= 1'b1;
            end
            K_PID: begin
              tx_byte   <= {~pid_q, pid_q};
              tx_enable <= 1'b1;
            end
            K_DATA: begin
              if (buffer_occupancy == '0) begin
                // Buffer ran dry: truncate and report as an error at the end.
                underrun <= 1'b1;
                state    <= S_EOP;
              end else begin
                get_tx_packet_data <= 1'b1;
                tx_byte            <= tx_packet_data;
                tx_enable          <= 1'b1;
                crc                <= crc_update(crc, tx_packet_data);
                count              <= count + 7'd1;
              end
            end
            K_CRC_LO: begin
              tx_byte   <= ~crc[7:0];
              tx_enable <= 1'b1;
            end
            K_CRC_HI: begin
              tx_byte   <= ~crc[15:8];
              tx_enable <= 1'b1;
            end
            default: state <= S_ERROR;
          endcase
        end

        S_WAIT: begin
          if (byte_done) begin
            state <= S_LOAD;
            case (kind)
              K_SYNC: kind <= K_PID;
              K_PID: begin
                if (!pid_is_data(pid_q)) state <= S_EOP;
                else if (len_q != '0)    kind  <= K_DATA;
                else                     kind  <= K_CRC_LO;
              end
              K_DATA: begin
                if (count == len_q) kind <= K_CRC_LO;
              end
              K_CRC_LO: kind  <= K_CRC_HI;
              K_CRC_HI: state <= S_EOP;
              default:  state <= S_ERROR;
            endcase
          end else if (wd_expired) begin
            state <= S_ERROR;
          end
        end

        S_EOP: begin
          send_eop <= 1'b1;
          state    <= S_WAIT_EOP;
        end

        S_WAIT_EOP: begin
          if (eop_done) begin
            state <= underrun ? S_ERROR : S_DONE;
          end else if (wd_expired) begin
            state <= S_ERROR;
          end
        end

        S_DONE: begin
          tx_done   <= 1'b1;
          tx_active <= 1'b0;
          state     <= S_IDLE;
        end

        S_ERROR: begin
          tx_error  <= 1'b1;
          tx_active <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_ctrl.sv
module tb_tx_packet_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = '0;
  logic [6:0] tx_length = '0;
  logic [6:0] buffer_occupancy = '0;
  logic [7:0] tx_packet_data = '0;
  logic       byte_done = 1'b0;
  logic       eop_done = 1'b0;
  logic       get_tx_packet_data;
  logic [7:0] tx_byte;
  logic       tx_enable;
  logic       send_eop;
  logic       tx_active;
  logic       tx_done;
  logic       tx_error;

  int checks = 0;
  int errors = 0;

  tx_packet_ctrl dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_pid             (tx_pid),
    .tx_length          (tx_length),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .byte_done          (byte_done),
    .eop_done           (eop_done),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_byte            (tx_byte),
    .tx_enable          (tx_enable),
    .send_eop           (send_eop),
    .tx_active          (tx_active),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (get_tx_packet_data !== 1'b0) begin errors++; $display("FAIL reset_pop got %b want 0", get_tx_packet_data); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", tx_byte); end
    checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", tx_enable); end
    checks++; if (send_eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b want 0", send_eop); end
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", tx_active); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    checks++; if (tx_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", tx_error); end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one packet acting as TX buffer and encoder, then checks the observed
  // byte stream, pops, EOP and completion against a model built from the rules.
  task automatic test_packet(input string tag, input logic [3:0] pid,
                             input int len, input int avail, input bit zeros);
    logic [7:0] bufq[$];
    logic [7:0] exp[$];
    logic [7:0] got[$];
    logic [15:0] c;
    logic [7:0] prev;
    logic [7:0] d;
    int pops = 0, eops = 0, bd = -1, ed = -1, cyc = 0, last_bd = -1;
    int unstable = 0, gap_bad = 0, active_bad = 0, n = 0, exp_pops;
    bit fin = 0, done_seen = 0, err_seen = 0, handshake, exp_err, end_active = 1;

    handshake = (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110);
    for (int i = 0; i < avail; i++) bufq.push_back(zeros ? 8'h00 : 8'($urandom));

    exp.push_back(8'h80);
    exp.push_back({~pid, pid});
    if (!handshake) begin
      n = (avail < len) ? avail : len;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
        d = bufq[i];
        exp.push_back(d);
        for (int b = 0; b < 8; b++)
          c = (c[0] ^ d[b]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      if (avail >= len) begin
        exp.push_back(~c[7:0]);
        exp.push_back(~c[15:8]);
      end
    end
    exp_err  = !handshake && (avail < len);
    exp_pops = handshake ? 0 : n;

    buffer_occupancy = 7'(bufq.size());
    tx_packet_data   = (bufq.size() > 0) ? bufq[0] : 8'h00;
    @(negedge clk);
    tx_start = 1'b1; tx_pid = pid; tx_length = 7'(len);
    @(negedge clk);
    tx_start = 1'b0;
    checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL %s active_rise got %b want 1", tag, tx_active); end
    prev = tx_byte;

    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      byte_done = 1'b0; eop_done = 1'b0; tx_start = 1'b0;
      if (cyc == 3) begin tx_start = 1'b1; tx_pid = 4'b0101; end
      if (tx_byte !== prev && tx_enable !== 1'b1) unstable++;
      prev = tx_byte;
      if (get_tx_packet_data === 1'b1) begin
        pops++;
        if (bufq.size() > 0) void'(bufq.pop_front());
        buffer_occupancy = 7'(bufq.size());
        tx_packet_data   = (bufq.size() > 0) ? bufq[0] : 8'h00;
      end
      if (tx_enable === 1'b1) begin
        got.push_back(tx_byte);
        if (last_bd < 0 ? (cyc != 1) : (cyc - last_bd != 2)) gap_bad++;
        bd = $urandom_range(0, 3);
      end
      if (send_eop === 1'b1) begin eops++; ed = $urandom_range(0, 3); end
      if (tx_done === 1'b1)  begin done_seen = 1; fin = 1; end
      if (tx_error === 1'b1) begin err_seen = 1; fin = 1; end
      if (fin) end_active = tx_active;
      else if (tx_active !== 1'b1) active_bad++;
      if (bd == 0) begin byte_done = 1'b1; last_bd = cyc; bd = -1; end
      else if (bd > 0) bd--;
      if (ed == 0) begin eop_done = 1'b1; ed = -1; end
      else if (ed > 0) ed--;
      // Pulses the controller must ignore outside the matching wait state.
      if (eops == 0 && !fin && !eop_done && $urandom_range(0, 3) == 0) eop_done = 1'b1;
      if (eops > 0 && !fin && !byte_done && $urandom_range(0, 3) == 0) byte_done = 1'b1;
    end
    byte_done = 1'b0; eop_done = 1'b0; tx_start = 1'b0;

    checks++; if (!fin) begin errors++; $display("FAIL %s finish got timeout want done/error", tag); end
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL %s byte_count got %0d want %0d", tag, got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL %s byte[%0d] got %h want %h", tag, i, got[i], exp[i]); end
    end
    checks++; if (pops != exp_pops) begin errors++; $display("FAIL %s pops got %0d want %0d", tag, pops, exp_pops); end
    checks++; if (eops != 1) begin errors++; $display("FAIL %s send_eop got %0d want 1", tag, eops); end
    checks++; if (err_seen != exp_err) begin errors++; $display("FAIL %s tx_error got %0d want %0d", tag, err_seen, exp_err); end
    checks++; if (done_seen != !exp_err) begin errors++; $display("FAIL %s tx_done got %0d want %0d", tag, done_seen, !exp_err); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL %s byte_hold got %0d changes want 0", tag, unstable); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL %s enable_latency got %0d bad want 0", tag, gap_bad); end
    checks++; if (active_bad != 0) begin errors++; $display("FAIL %s active_hold got %0d drops want 0", tag, active_bad); end
    checks++; if (end_active !== 1'b0) begin errors++; $display("FAIL %s active_fall got %b want 0", tag, end_active); end
    @(negedge clk);
    checks++; if (tx_done !== 1'b0 || tx_error !== 1'b0) begin errors++; $display("FAIL %s pulse_width got %b%b want 00", tag, tx_done, tx_error); end
  endtask

  task automatic test_handshake();
    logic [3:0] hs[3] = '{4'b0010, 4'b1010, 4'b1110};
    test_packet("ack_directed", 4'b0010, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      test_packet("handshake_rand", hs[$urandom_range(0, 2)], $urandom_range(0, 64), 4, 0);
  endtask

  task automatic test_zero_length();
    test_packet("data0_len0", 4'b0011, 0, 0, 0);
  endtask

  task automatic test_single_byte();
    test_packet("data1_len1_zero", 4'b1011, 1, 1, 1);
  endtask

  task automatic test_random_data();
    int len;
    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(1, 63);
      test_packet("data_rand", ($urandom_range(0, 1) != 0) ? 4'b1011 : 4'b0011, len, len, 0);
    end
    test_packet("data_len64", 4'b0011, 64, 64, 0);
  endtask

  task automatic test_underrun();
    int len;
    test_packet("underrun_directed", 4'b0011, 3, 1, 0);
    len = $urandom_range(2, 40);
    test_packet("underrun_rand", 4'b1011, len, $urandom_range(0, len - 1), 0);
  endtask

  task automatic test_bad_pid();
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) p = 4'b0101;
      else begin
        do p = 4'($urandom);
        while (p == 4'b0011 || p == 4'b1011 || p == 4'b0010 || p == 4'b1010 || p == 4'b1110);
      end
      @(negedge clk);
      tx_start = 1'b1; tx_pid = p; tx_length = 7'd5;
      @(negedge clk);
      tx_start = 1'b0;
      checks++; if (tx_active !== 1'b0 || tx_error !== 1'b0) begin errors++; $display("FAIL bad_pid_early got active=%b err=%b want 0 0", tx_active, tx_error); end
      @(negedge clk);
      checks++; if (tx_error !== 1'b1) begin errors++; $display("FAIL bad_pid_error got %b want 1 (pid %b)", tx_error, p); end
      checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL bad_pid_enable got %b want 0", tx_enable); end
      @(negedge clk);
      checks++; if (tx_error !== 1'b0 || tx_enable !== 1'b0) begin errors++; $display("FAIL bad_pid_after got err=%b en=%b want 0 0", tx_error, tx_enable); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int strobes = 0;
    buffer_occupancy = 7'd8; tx_packet_data = 8'h5A;
    @(negedge clk);
    tx_start = 1'b1; tx_pid = 4'b0011; tx_length = 7'd8;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      byte_done = tx_enable;
    end
    byte_done = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL async_reset_active got %b want 0", tx_active); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL async_reset_byte got %h want 00", tx_byte); end
    checks++; if ({tx_enable, send_eop, get_tx_packet_data, tx_done, tx_error} !== 5'b0) begin
      errors++; $display("FAIL async_reset_strobes got %b want 00000", {tx_enable, send_eop, get_tx_packet_data, tx_done, tx_error});
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_enable === 1'b1 || send_eop === 1'b1 || tx_active === 1'b1) strobes++;
    end
    checks++; if (strobes != 0) begin errors++; $display("FAIL post_reset_quiet got %0d strobes want 0", strobes); end
  endtask

`ifdef TX_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0, seen = 0, eops = 0;
    @(negedge clk);
    tx_start = 1'b1; tx_pid = 4'b0011; tx_length = 7'd0;
    @(negedge clk);
    tx_start = 1'b0;
    while (seen == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (send_eop === 1'b1) eops++;
      if (tx_error === 1'b1) seen = cyc;
    end
    checks++; if (seen < 255 || seen > 260) begin errors++; $display("FAIL timeout_error got cycle %0d want ~257", seen); end
    checks++; if (eops != 0) begin errors++; $display("FAIL timeout_eop got %0d want 0", eops); end
    @(negedge clk);
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL timeout_idle got active %b want 0", tx_active); end
  endtask
`endif

  initial begin
    test_reset();
    test_handshake();
    test_zero_length();
    test_single_byte();
    test_random_data();
    test_underrun();
    test_bad_pid();
    test_reset_mid_packet();
    test_packet("after_reset", 4'b1011, 5, 5, 0);
`ifdef TX_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
